dcache_inv_queue: RTL and testbench

DCACHE_INV_QUEUE -- requirements
Module: dcache_inv_queue

---
 rtl/taiga_config.sv | 16 +
 rtl/taiga_types.sv | 26 ++
 rtl/dcache_inv_queue_if.sv | 30 +++
 rtl/inv_addr_fifo.sv | 85 ++++++++
 rtl/dcache_inv_queue.sv | 99 +++++++++
 tb/tb_dcache_inv_queue.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/taiga_config.sv
// Build-time configuration for the data cache invalidation path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package taiga_config;

    // 16-byte lines: 4 words per line, 4 bytes per word.
    localparam int DCACHE_LINE_ADDR_W     = 8;
    localparam int DCACHE_SUB_LINE_ADDR_W = 2;
    localparam int DCACHE_BYTE_ADDR_W     = 2;
    localparam int DCACHE_LINE_OFFSET_W   = DCACHE_SUB_LINE_ADDR_W + DCACHE_BYTE_ADDR_W;
    localparam int DCACHE_TAG_W           = 32 - DCACHE_LINE_ADDR_W - DCACHE_LINE_OFFSET_W;

    // Buffered invalidations; must be a power of two and at least 2.
    localparam int DCACHE_INV_QUEUE_DEPTH = 4;

endpackage

// File: rtl/taiga_types.sv
// Shared types for the invalidation queue: entry layout, FSM states, address rebuild.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package taiga_types;
    import taiga_config::*;

    // One buffered invalidation: only the bits that identify a cache line.
    typedef struct packed {
        logic                          valid;
        logic [DCACHE_TAG_W-1:0]       tag;
        logic [DCACHE_LINE_ADDR_W-1:0] line;
    } inv_entry_t;

    typedef enum logic [1:0] {
        INV_IDLE  = 2'd0,
        INV_ISSUE = 2'd1,
        INV_GAP   = 2'd2
    } inv_state_t;

    // Rebuild a byte address with the sub-line and byte offset forced to zero.
    function automatic logic [31:0] line_to_addr(input logic [DCACHE_TAG_W-1:0] tag,
                                                 input logic [DCACHE_LINE_ADDR_W-1:0] line);
        return {tag, line, {DCACHE_LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_inv_queue_if.sv
// Snoop intake and tag-bank invalidation signals of the invalidation queue.
// Latency: n/a (wiring only).
// Backpressure: snoop_ready from the queue; extern_inv held until extern_inv_complete.
interface dcache_inv_queue_if #(
    parameter int INV_QUEUE_DEPTH = taiga_config::DCACHE_INV_QUEUE_DEPTH
);
    localparam int CNT_W = $clog2(INV_QUEUE_DEPTH) + 1;

    logic             snoop_valid;
    logic [31:0]      snoop_addr;
    logic             snoop_ready;
    logic             extern_inv;
    logic [31:0]      inv_addr;
    logic             extern_inv_complete;
    logic             inv_pending;
    logic [CNT_W-1:0] inv_count;

    // Environment side: snooping cores and the tag banks.
    modport master (
        output snoop_valid, snoop_addr, extern_inv_complete,
        input  snoop_ready, extern_inv, inv_addr, inv_pending, inv_count
    );

    // Queue side.
    modport slave (
        input  snoop_valid, snoop_addr, extern_inv_complete,
        output snoop_ready, extern_inv, inv_addr, inv_pending, inv_count
    );

endinterface

// File: rtl/inv_addr_fifo.sv
// Circular store of pending line addresses with per-entry valids exposed for coalescing.
// Latency: push visible at head/count one cycle after the accepting edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with count.
module inv_addr_fifo
    import taiga_config::*;
    import taiga_types::*;
#(
    parameter int DEPTH = DCACHE_INV_QUEUE_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DCACHE_TAG_W-1:0]       i_push_tag,
    input  logic [DCACHE_LINE_ADDR_W-1:0] i_push_line,
    input  logic                          i_pop,
    output inv_entry_t [DEPTH-1:0]        o_entries,
    output inv_entry_t                    o_head,
    output logic [$clog2(DEPTH)-1:0]      o_rd_ptr,
    output logic [$clog2(DEPTH):0]        o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]              r_valid;
    logic [DCACHE_TAG_W-1:0]       r_tag  [DEPTH];
    logic [DCACHE_LINE_ADDR_W-1:0] r_line [DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [CNT_W-1:0]              r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    // Pointers, valids and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Address payload; qualified by r_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr]  <= i_push_tag;
            r_line[r_wr_ptr] <= i_push_line;
        end
    end

    // Present every slot to the coalescing compare in the parent.
    always_comb begin
        o_entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entries[i] = {r_valid[i], r_tag[i], r_line[i]};
        end
    end

    assign o_head   = {r_valid[r_rd_ptr], r_tag[r_rd_ptr], r_line[r_rd_ptr]};
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/dcache_inv_queue.sv
// Buffers remote-write snoops, coalesces duplicate lines, issues them one at a time to the tag banks.
// Latency: push -> extern_inv 2 cycles; each entry costs >=1 ISSUE cycle plus 1 GAP cycle.
// Backpressure: snoop_ready = ~full from registered count; extern_inv held until extern_inv_complete.
module dcache_inv_queue
    import taiga_config::*;
    import taiga_types::*;
#(
    parameter int INV_QUEUE_DEPTH = DCACHE_INV_QUEUE_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    dcache_inv_queue_if.slave  inv_if
);
    localparam int PTR_W    = $clog2(INV_QUEUE_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int LINE_LSB = DCACHE_LINE_OFFSET_W;
    localparam int TAG_LSB  = LINE_LSB + DCACHE_LINE_ADDR_W;

    inv_state_t r_state;
    inv_state_t w_next_state;

    inv_entry_t [INV_QUEUE_DEPTH-1:0] w_entries;
    inv_entry_t                       w_head;
    logic [PTR_W-1:0]                 w_rd_ptr;
    logic [CNT_W-1:0]                 w_count;

    logic [DCACHE_TAG_W-1:0]       w_snoop_tag;
    logic [DCACHE_LINE_ADDR_W-1:0] w_snoop_line;
    logic                          w_unused_offset;
    logic                          w_full;
    logic                          w_pop;
    logic                          w_match;
    logic                          w_push;

    assign w_snoop_tag     = inv_if.snoop_addr[31:TAG_LSB];
    assign w_snoop_line    = inv_if.snoop_addr[TAG_LSB-1:LINE_LSB];
    assign w_unused_offset = |inv_if.snoop_addr[LINE_LSB-1:0];

    assign w_full = (w_count == CNT_W'(INV_QUEUE_DEPTH));
    assign w_pop  = (r_state == INV_ISSUE) & inv_if.extern_inv_complete;

    // Coalesce against any live entry, except the head leaving this very edge:
    // that line has already been invalidated, so a fresh write must be queued again.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < INV_QUEUE_DEPTH; i++) begin
            if (w_entries[i].valid &&
                (w_entries[i].tag == w_snoop_tag) &&
                (w_entries[i].line == w_snoop_line) &&
                !(w_pop && (PTR_W'(i) == w_rd_ptr))) begin
                w_match = 1'b1;
            end
        end
    end

    assign w_push = inv_if.snoop_valid & ~w_full & ~w_match;

    inv_addr_fifo #(
        .DEPTH (INV_QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_tag  (w_snoop_tag),
        .i_push_line (w_snoop_line),
        .i_pop       (w_pop),
        .o_entries   (w_entries),
        .o_head      (w_head),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (w_count)
    );

    // State register; reset abandons any invalidation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: the GAP cycle drops extern_inv so the downstream accessed flag clears.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INV_IDLE:  if (w_count != '0) w_next_state = INV_ISSUE;
            INV_ISSUE: if (inv_if.extern_inv_complete) w_next_state = INV_GAP;
            INV_GAP:   w_next_state = (w_count != '0) ? INV_ISSUE : INV_IDLE;
            default:   w_next_state = INV_IDLE;
        endcase
    end

    assign inv_if.snoop_ready = ~w_full;
    assign inv_if.extern_inv  = (r_state == INV_ISSUE);
    assign inv_if.inv_addr    = w_head.valid ? line_to_addr(w_head.tag, w_head.line) : 32'h0;
    assign inv_if.inv_pending = (w_count != '0) | (r_state != INV_IDLE);
    assign inv_if.inv_count   = w_count;

endmodule

// File: tb/tb_dcache_inv_queue.sv
// Directed and random stimulus for dcache_inv_queue against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: bench plays snooping cores and tag banks.
module tb_dcache_inv_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dcache_inv_queue_if #(.INV_QUEUE_DEPTH(DEPTH)) bus ();

    dcache_inv_queue #(.INV_QUEUE_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst_n),
        .inv_if (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending line addresses in issue order, plus protocol phase
    // (0 = idle, 1 = invalidation presented, 2 = one-cycle gap after completion).
    logic [31:0] mq[$];
    int          mst = 0;
    logic [31:0] issued[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst = 0;
    endtask

    // Check outputs against the model, drive one cycle of inputs, advance model and clock.
    task automatic cycle(input logic sv, input logic [31:0] a, input logic cpl);
        int          sz;
        logic        pop;
        logic        acc;
        logic        hit;
        logic [31:0] line;
        sz = mq.size();
        chk("inv_count",   32'(bus.inv_count),   32'(sz));
        chk("snoop_ready", 32'(bus.snoop_ready), 32'(sz < DEPTH));
        chk("extern_inv",  32'(bus.extern_inv),  32'(mst == 1));
        chk("inv_addr",    bus.inv_addr,         (sz != 0) ? mq[0] : 32'h0);
        chk("inv_pending", 32'(bus.inv_pending), 32'((sz != 0) || (mst != 0)));
        bus.snoop_valid         = sv;
        bus.snoop_addr          = a;
        bus.extern_inv_complete = cpl;
        pop  = (mst == 1) && cpl;
        acc  = sv && (sz < DEPTH);
        line = a & 32'hFFFF_FFF0;
        case (mst)
            0:       mst = (sz != 0) ? 1 : 0;
            1:       mst = cpl ? 2 : 1;
            default: mst = (sz != 0) ? 1 : 0;
        endcase
        if (pop) void'(mq.pop_front());
        if (acc) begin
            hit = 1'b0;
            foreach (mq[k]) if (mq[k] == line) hit = 1'b1;
            if (!hit) mq.push_back(line);
        end
        @(posedge clk);
        #1;
    endtask

    // Act as tag banks answering after lat ISSUE cycles; optionally hold one snoop until taken.
    task automatic run(input int lat, input logic hold_v, input logic [31:0] hold_a, input int maxc);
        int   hi;
        int   n;
        logic holding;
        logic cpl;
        logic room;
        hi      = 0;
        n       = 0;
        holding = hold_v;
        while ((mq.size() != 0 || mst != 0 || holding) && n < maxc) begin
            if (mst == 1) hi++; else hi = 0;
            cpl  = (mst == 1) && (hi >= lat);
            room = (mq.size() < DEPTH);
            if (cpl) issued.push_back(bus.inv_addr);
            cycle(holding, hold_a, cpl);
            if (holding && room) holding = 1'b0;
            n++;
        end
        chk("drain_budget", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n                   = 1'b0;
        bus.snoop_valid         = 1'b0;
        bus.snoop_addr          = 32'h0;
        bus.extern_inv_complete = 1'b0;
        #2;
        chk("rst_extern_inv",  32'(bus.extern_inv),  32'd0);
        chk("rst_snoop_ready", 32'(bus.snoop_ready), 32'd1);
        chk("rst_inv_count",   32'(bus.inv_count),   32'd0);
        chk("rst_inv_pending", 32'(bus.inv_pending), 32'd0);
        chk("rst_inv_addr",    bus.inv_addr,         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Single snoop: line-aligned address, two ISSUE cycles, one GAP, then idle.
        cycle(1'b1, 32'h0000_1234, 1'b0);
        chk("s1_count", 32'(bus.inv_count), 32'd1);
        chk("s1_idle_ext", 32'(bus.extern_inv), 32'd0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("s1_issue1_ext", 32'(bus.extern_inv), 32'd1);
        chk("s1_addr", bus.inv_addr, 32'h0000_1230);
        cycle(1'b0, 32'h0, 1'b0);
        chk("s1_issue2_ext", 32'(bus.extern_inv), 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("s1_gap_ext", 32'(bus.extern_inv), 32'd0);
        chk("s1_gap_pending", 32'(bus.inv_pending), 32'd1);
        cycle(1'b0, 32'h0, 1'b0);
        chk("s1_done_pending", 32'(bus.inv_pending), 32'd0);

        // Coalescing: 0x104 shares 0x100's line.
        cycle(1'b1, 32'h100, 1'b0);
        cycle(1'b1, 32'h104, 1'b0);
        cycle(1'b1, 32'h200, 1'b0);
        chk("coal_count", 32'(bus.inv_count), 32'd2);
        issued.delete();
        run(2, 1'b0, 32'h0, 40);
        chk("coal_n_issued", 32'(issued.size()), 32'd2);
        chk("coal_first", issued[0], 32'h100);
        chk("coal_second", issued[1], 32'h200);

        // Fill to depth, hold a fifth snoop; pointers wrap and order is kept.
        cycle(1'b1, 32'h1000, 1'b0);
        cycle(1'b1, 32'h2000, 1'b0);
        cycle(1'b1, 32'h3000, 1'b0);
        cycle(1'b1, 32'h4000, 1'b0);
        chk("full_count", 32'(bus.inv_count), 32'd4);
        chk("full_ready", 32'(bus.snoop_ready), 32'd0);
        issued.delete();
        run(3, 1'b1, 32'h5000, 80);
        chk("full_n_issued", 32'(issued.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("full_order", issued[i], 32'((i + 1) * 32'h1000));

        // Stalled completion, then stray completions in GAP and IDLE.
        cycle(1'b1, 32'h7770, 1'b0);
        cycle(1'b1, 32'h9990, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            chk("stall_ext", 32'(bus.extern_inv), 32'd1);
            chk("stall_addr", bus.inv_addr, 32'h7770);
        end
        cycle(1'b0, 32'h0, 1'b1);
        chk("stall_gap_count", 32'(bus.inv_count), 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("stray_gap_count", 32'(bus.inv_count), 32'd1);
        chk("stray_gap_addr", bus.inv_addr, 32'h9990);
        run(2, 1'b0, 32'h0, 30);
        cycle(1'b1, 32'h8880, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("stray_idle_count", 32'(bus.inv_count), 32'd1);
        run(2, 1'b0, 32'h0, 30);

        // Duplicate of head in flight is dropped; duplicate of popping head is re-queued.
        cycle(1'b1, 32'hA000, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'hA004, 1'b0);
        chk("inflight_coal_count", 32'(bus.inv_count), 32'd1);
        cycle(1'b1, 32'hA008, 1'b1);
        chk("pop_requeue_count", 32'(bus.inv_count), 32'd1);
        issued.delete();
        run(2, 1'b0, 32'h0, 30);
        chk("pop_requeue_n", 32'(issued.size()), 32'd1);
        chk("pop_requeue_addr", issued[0], 32'hA000);

        // Reset while ISSUE with three entries.
        cycle(1'b1, 32'h1000, 1'b0);
        cycle(1'b1, 32'h2000, 1'b0);
        cycle(1'b1, 32'h3000, 1'b0);
        chk("pre_rst_ext", 32'(bus.extern_inv), 32'd1);
        #3;
        bus.snoop_valid         = 1'b0;
        bus.extern_inv_complete = 1'b0;
        rst_n                   = 1'b0;
        #1;
        chk("mid_rst_extern_inv",  32'(bus.extern_inv),  32'd0);
        chk("mid_rst_snoop_ready", 32'(bus.snoop_ready), 32'd1);
        chk("mid_rst_inv_count",   32'(bus.inv_count),   32'd0);
        chk("mid_rst_inv_pending", 32'(bus.inv_pending), 32'd0);
        chk("mid_rst_inv_addr",    bus.inv_addr,         32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h4440, 1'b0);
        issued.delete();
        run(2, 1'b0, 32'h0, 30);
        chk("post_rst_n", 32'(issued.size()), 32'd1);
        chk("post_rst_addr", issued[0], 32'h4440);

        // Random snoops over a few lines with random (often stray) completions.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 5) << 4) | $urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 2) == 0));
        end
        run(2, 1'b0, 32'h0, 60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
